// File: rtl/sig_shaper_pkg.sv
// Shared types and elaboration helpers for the sig pulse shaper.
package sig_shaper_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW_GAP = 2'd2
  } shaper_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // MAX_HIGH of 0 means the high time is unbounded.
  function automatic bit shaper_params_ok(input int min_high, input int min_low,
                                          input int max_high);
    return (min_high >= 1) && (min_low >= 1) &&
           ((max_high == 0) || (max_high >= min_high));
  endfunction

endpackage

// File: rtl/sig_pulse_shaper.sv
// Turns a raw request level into a registered strobe with guaranteed minimum
// high time, optional maximum high time and a minimum low gap between pulses.
module sig_pulse_shaper
  import sig_shaper_pkg::*;
#(
  parameter int MIN_HIGH = 2,
  parameter int MIN_LOW  = 1,
  parameter int MAX_HIGH = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_in,
  output logic sig,
  output logic busy,
  output logic trunc
);

  localparam int CNT_W = $clog2(max3(MIN_HIGH, MIN_LOW, MAX_HIGH) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MIN_LOW_C  = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH);

  if (!shaper_params_ok(MIN_HIGH, MIN_LOW, MAX_HIGH)) begin : g_param_err
    $error("sig_pulse_shaper: illegal MIN_HIGH/MIN_LOW/MAX_HIGH combination");
  end

  shaper_state_t    state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             pend, next_pend;
  logic             next_trunc, next_sig, next_busy;

  // State register with registered outputs; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      sig   <= 1'b0;
      busy  <= 1'b0;
      trunc <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      pend  <= next_pend;
      sig   <= next_sig;
      busy  <= next_busy;
      trunc <= next_trunc;
    end
  end

  // Next-state, counter and pending-request logic.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_pend  = pend;
    next_trunc = 1'b0;
    case (state)
      IDLE: begin
        if (en && req_in) begin
          next_state = HIGH;
          next_cnt   = CNT_ONE;
        end else begin
          next_state = IDLE;
        end
      end
      HIGH: begin
        if ((cnt >= MIN_HIGH_C) && !req_in) begin
          next_state = LOW_GAP;
          next_cnt   = CNT_ONE;
          next_pend  = 1'b0;
        end else if ((MAX_HIGH != 0) && (cnt == MAX_HIGH_C)) begin
          next_state = LOW_GAP;
          next_cnt   = CNT_ONE;
          next_pend  = 1'b0;
          next_trunc = 1'b1;
        end else begin
          next_cnt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end
      end
      LOW_GAP: begin
        if (cnt >= MIN_LOW_C) begin
          // A request latched during the gap is dropped if en is low here.
          if ((pend || req_in) && en) begin
            next_state = HIGH;
            next_cnt   = CNT_ONE;
          end else begin
            next_state = IDLE;
          end
          next_pend = 1'b0;
        end else begin
          next_cnt  = cnt + CNT_ONE;
          next_pend = pend | req_in;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
        next_pend  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so sig/busy register alongside it.
  always_comb begin
    next_sig  = (next_state == HIGH);
    next_busy = (next_state != IDLE);
  end

endmodule

// File: doc/sig_pulse_shaper.md
# sig_pulse_shaper

Upstream conditioning stage that produces the `sig` strobe consumed by the pulse-width checkers. It converts a raw level/pulse request `req_in` into a registered `sig` that is guaranteed high for at least MIN_HIGH consecutive clock cycles, optionally capped at MAX_HIGH, and then low for at least MIN_LOW cycles before it may rise again. Every rising edge of `sig` therefore satisfies the rule `$rose(sig) |-> sig[*MIN_HIGH]`.

## Interface
- MIN_HIGH, 2, minimum high time of `sig` in cycles; must be ≥ 1.
- MIN_LOW, 1, minimum low gap between pulses in cycles; must be ≥ 1.
- MAX_HIGH, 0, maximum high time in cycles; 0 means unlimited; otherwise must be ≥ MIN_HIGH.
- CNT_W, derived, counter width: $clog2(max(MIN_HIGH, MIN_LOW, MAX_HIGH) + 1).
- Any parameter violation is an elaboration-time $error.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  enable for starting new pulses; does not abort a pulse already in progress.
- req_in  input  1  request level, sampled on every posedge.
- sig  output  1  shaped strobe (registered).
- busy  output  1  high whenever the state is not IDLE (registered).
- trunc  output  1  one-cycle pulse, asserted in the cycle after `sig` is forced low by MAX_HIGH.

## Operation
- There is one clock, `clk`. Reset `reset` is synchronous and active-high.
- Reset values:
  - `sig` = 0, `busy` = 0, `trunc` = 0.
  - State = IDLE, `cnt` = 0, `pend` = 0.
- FSM states: IDLE, HIGH, LOW_GAP.
- IDLE (`sig` = 0):
  - If `en` && `req_in` at an edge: go to HIGH, `sig` <= 1, `cnt` <= 1.
  - Otherwise stay in IDLE.
- HIGH (`sig` = 1), evaluated at each edge in this priority order:
  - If `cnt` ≥ MIN_HIGH && !`req_in`: fall.
  - Else if MAX_HIGH != 0 && `cnt` == MAX_HIGH: fall and set `trunc` <= 1.
  - Else `cnt` <= `cnt` + 1 (saturating).
  - A fall means: `sig` <= 0, go to LOW_GAP, `cnt` <= 1, `pend` <= 0.
- LOW_GAP (`sig` = 0):
  - If `req_in` is sampled high at any edge in this state, `pend` <= 1. A short request is latched, never lost.
  - When `cnt` ≥ MIN_LOW: if (`pend` || `req_in`) && `en`, go to HIGH with `sig` <= 1, `cnt` <= 1, `pend` <= 0. Otherwise go to IDLE and clear `pend`.
  - Else `cnt` <= `cnt` + 1.
- `en` low with a pending request at the end of the gap drops that request.
- `trunc` is high for exactly one cycle and is 0 otherwise.
- `busy` = (next state != IDLE), registered alongside `sig`.

## Timing
- Rise latency: `req_in` sampled high at edge k (in IDLE, with `en`) gives `sig` = 1 after edge k.
- High time is at least MIN_HIGH cycles, so `sig` is sampled high at edges k+1 … k+MIN_HIGH.
- `req_in` held longer keeps `sig` high. `sig` falls at the first edge where `req_in` is sampled low and `cnt` ≥ MIN_HIGH.
- With MAX_HIGH set, high time never exceeds MAX_HIGH cycles.
- Gap: after a fall at edge j, the earliest re-rise is edge j+MIN_LOW.
- A 1-cycle `req_in` pulse still yields a full MIN_HIGH-cycle `sig` pulse.
- Reset mid-pulse: `sig` goes low after the reset edge. MIN_HIGH is not enforced, consistent with the checker's disable condition. No `trunc` pulse is produced.
- Reset has priority over all FSM transitions.
- `cnt` saturates; it never wraps.

## Structure
- `sig_shaper_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, HIGH, LOW_GAP} shaper_state_t`
  - parameter-check helper function
- Single module with no sub-module. The counter is inline.
- The existing assertion `$rose(sig) |-> sig[*MIN_HIGH]` (disable iff `reset`) is bound to the module in verification.

## Test plan
- MIN_HIGH=2, MIN_LOW=1: 1-cycle `req_in` at edge 10 → `sig` high at edges 11–12, low at edge 13; `busy` 1 over edges 11–13; `trunc` stays 0.
- MIN_HIGH=2: `req_in` held high for edges 10–15 → `sig` high at edges 11–16, falls after edge 16.
- MAX_HIGH=4: `req_in` held high for 10 cycles from edge 10 → `sig` high at edges 11–14; `trunc` = 1 at edge 15 only; re-rises after edge 15 (`req_in` still high, MIN_LOW=1).
- MIN_LOW=3: second 1-cycle request arriving 1 cycle after the fall → `pend` set; `sig` stays low 3 cycles, then a full 2-cycle pulse follows.
- `reset` = 1 during the first high cycle → `sig`, `busy`, `trunc` all 0 after that edge; state IDLE; bound assertion reports no failure.
- `en` = 0 with `req_in` high → `sig` stays 0; dropping `en` mid-pulse → pulse completes at full MIN_HIGH width.
